fifo_rr_write_arbiter: RTL
==========================

Name: fifo_rr_write_arbiter

Overview:
- Shares the write port of one fifo instance among NUM_REQ ready/valid requesters.
- Uses round-robin arbitration with packet lock, so a grant is held until the requester's last beat or until a burst limit is reached.
- Sits between producer modules and the fifo w_req/w_data/w_stall port.
- Forwards the source ID with each beat so a side fifo can store it.

Parameters:
- NUM_REQ, 4, number of requesters (minimum 2).
- COL_BIT_WIDTH, 32, data beat width; matches the fifo COL_BIT_WIDTH.
- BURST_MAX, 4, maximum beats per grant before forced re-arbitration (minimum 1).
- ID_WIDTH, $clog2(NUM_REQ), localparam, width of the requester index.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester beat valid
- req_last  in  NUM_REQ  marks the final beat of a packet; qualified by req_valid
- req_data  in  NUM_REQ*COL_BIT_WIDTH  packed beats; requester i occupies bits [i*W +: W]
- req_ready  out  NUM_REQ  per-requester beat accepted
- fifo_w_req  out  1  drives fifo w_req
- fifo_w_data  out  COL_BIT_WIDTH  drives fifo w_data
- fifo_w_id  out  ID_WIDTH  source index of the current beat
- fifo_w_stall  in  1  fifo full
- grant_active  out  1  a requester currently holds the grant
- grant_id  out  ID_WIDTH  index of the granted requester

Behaviour:
- Reset (asynchronous, any cycle, including mid-packet):
  - state=IDLE, grant_id=0, rr_ptr=NUM_REQ-1, beat_cnt=0.
  - All outputs read 0.
  - An in-flight packet is abandoned with no further beats.
- Registered state: state {IDLE, GRANT}, grant_id, rr_ptr (last released requester), beat_cnt (width $clog2(BURST_MAX+1)).
- Pick function (combinational):
  - Scans req_valid starting at rr_ptr+1 modulo NUM_REQ and wraps.
  - rr_ptr itself is examined last.
  - Outputs pick_idx and pick_any.
- IDLE:
  - All outputs are 0.
  - If pick_any: next cycle state=GRANT, grant_id=pick_idx, beat_cnt=0.
  - Arbitration latency is 1 cycle; no beat transfers in the IDLE cycle.
- GRANT (g=grant_id):
  - grant_active=1, grant_id=g.
  - req_ready[g] = !fifo_w_stall; all other req_ready are 0.
  - fifo_w_req = req_valid[g] & !fifo_w_stall.
  - fifo_w_data = req_data[g] when fifo_w_req=1, else 0.
  - fifo_w_id = g.
  - xfer = req_valid[g] & !fifo_w_stall. On xfer, beat_cnt increments.
- Release:
  - Condition: xfer & (req_last[g] | beat_cnt==BURST_MAX-1).
  - On release, rr_ptr <= g and beat_cnt <= 0.
  - Re-arbitration uses the pick function with pointer g on the same-cycle req_valid.
  - If pick_any: stay in GRANT with grant_id <= pick_idx, so back-to-back grants have zero bubble cycles.
  - If not pick_any: go to IDLE.
  - Requester g may be re-picked only when it is the sole valid requester.
- Valid dropped while granted: the grant is held (packet lock), no beat transfers, beat_cnt holds.
- FIFO full (fifo_w_stall=1): no transfer, state/beat_cnt/grant hold, req_ready=0, fifo_w_req=0.
- A burst-limit release with req_last=0 leaves the packet open; its remaining beats are sent on a later grant, and fifo_w_id preserves the source.
- Non-granted requesters see req_ready=0 and must hold their data stable.
- Throughput is 1 beat/cycle while granted and not stalled.

Decomposition:
- Package fifo_arb_pkg:
  - arb_state_t enum {IDLE, GRANT}.
  - Default constants NUM_REQ_DEF=4, BURST_MAX_DEF=4.
- Sub-module rr_priority_pick (combinational):
  - Parameter NUM_REQ.
  - Inputs: req vector, ptr. Outputs: pick_idx, pick_any.
  - Instantiated once in the arbiter.

Test Plan:
- Single requester, R1 sends a 3-beat packet (A,B,C; last on C), fifo not full -> IDLE 1 cycle, then fifo_w_data A,B,C on 3 consecutive cycles with fifo_w_id=1, then IDLE; fifo head reads A,B,C.
- R0 and R2 each assert continuous 1-beat packets from reset -> grant order 0,2,0,2 with no bubble cycles after the first grant.
- BURST_MAX=4, R3 sends a 6-beat packet while R0 sends 1-beat packets -> beats 1-4 from R3, 1 beat from R0, then R3 beats 5-6; fifo_w_id sequence 3,3,3,3,0,3,3.
- Fifo filled to 8 entries (w_stall=1) with R1 granted mid-packet for 3 cycles -> req_ready[1]=0 and fifo_w_req=0 throughout; grant_id stays 1; after one fifo read, exactly 1 beat is accepted.
- reset_n pulsed low for 1 cycle mid-packet (R2, beat 2 of 4) -> all outputs 0 asynchronously; after release, R2 is re-arbitrated from IDLE with rr_ptr=NUM_REQ-1.
- All 4 requesters valid continuously with 1-beat packets -> grants cycle 0,1,2,3,0; no requester waits more than 3 grants.

Source files
------------

// File: rtl/fifo_rr_write_arbiter_pkg.sv
// fifo_arb_pkg: shared state type and default sizing for the fifo write arbiter
package fifo_arb_pkg;
    typedef enum logic {IDLE, GRANT} arb_state_t;
    localparam int NUM_REQ_DEF   = 4;
    localparam int BURST_MAX_DEF = 4;
endpackage

// File: rtl/fifo_rr_write_arbiter_if.sv
// fifo_rr_write_arbiter_if: requester-side and fifo write-side signals of the arbiter
interface fifo_rr_write_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ       = NUM_REQ_DEF,
    parameter int COL_BIT_WIDTH = 32
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0]               req_last;
    logic [NUM_REQ*COL_BIT_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]               req_ready;
    logic                             fifo_w_req;
    logic [COL_BIT_WIDTH-1:0]         fifo_w_data;
    logic [ID_WIDTH-1:0]              fifo_w_id;
    logic                             fifo_w_stall;
    logic                             grant_active;
    logic [ID_WIDTH-1:0]              grant_id;
    modport master (
        output req_valid, req_last, req_data, fifo_w_stall,
        input  req_ready, fifo_w_req, fifo_w_data, fifo_w_id, grant_active, grant_id
    );
    modport slave (
        input  req_valid, req_last, req_data, fifo_w_stall,
        output req_ready, fifo_w_req, fifo_w_data, fifo_w_id, grant_active, grant_id
    );
endinterface

// File: rtl/fifo_rr_write_arbiter_rr_priority_pick.sv
// rr_priority_pick: first set request after ptr, wrapping, with ptr itself examined last
module rr_priority_pick #(
    parameter int  NUM_REQ  = 4,
    localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [ID_WIDTH-1:0] pick_idx,
    output logic                pick_any
);
    logic [ID_WIDTH-1:0] idx;
    always_comb begin
        pick_idx = '0;
        idx      = '0;
        pick_any = |req;
        // scan from the far end so the nearest candidate after ptr is written last
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
            if (req[idx]) pick_idx = idx;
        end
    end
endmodule

// File: rtl/fifo_rr_write_arbiter.sv
// fifo_rr_write_arbiter: round-robin, packet-locked sharing of one fifo write port
module fifo_rr_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ       = NUM_REQ_DEF,
    parameter int COL_BIT_WIDTH = 32,
    parameter int BURST_MAX     = BURST_MAX_DEF
) (
    input logic                    clk,
    input logic                    reset_n,
    fifo_rr_write_arbiter_if.slave bus
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);
    localparam int CW       = $clog2(BURST_MAX + 1);
    arb_state_t          state, state_nx;
    logic [ID_WIDTH-1:0] gid, gid_nx, rr_ptr, rr_ptr_nx, pick_idx;
    logic [CW-1:0]       beat_cnt, beat_cnt_nx;
    logic                pick_any, granted, xfer, rel;
    assign granted = state == GRANT;
    assign xfer    = granted & bus.req_valid[gid] & ~bus.fifo_w_stall;
    assign rel     = xfer & (bus.req_last[gid] | beat_cnt == CW'(BURST_MAX - 1));
    // while granted the pointer only matters on release, where it must be the releasing requester
    rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req      (bus.req_valid),
        .ptr      (granted ? gid : rr_ptr),
        .pick_idx (pick_idx),
        .pick_any (pick_any)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            gid      <= '0;
            rr_ptr   <= ID_WIDTH'(NUM_REQ - 1);
            beat_cnt <= '0;
        end else begin
            state    <= state_nx;
            gid      <= gid_nx;
            rr_ptr   <= rr_ptr_nx;
            beat_cnt <= beat_cnt_nx;
        end
    end
    always_comb begin
        state_nx    = state;
        gid_nx      = gid;
        rr_ptr_nx   = rr_ptr;
        beat_cnt_nx = beat_cnt;
        if (!granted) begin
            state_nx    = pick_any ? GRANT : IDLE;
            gid_nx      = pick_any ? pick_idx : gid;
            beat_cnt_nx = '0;
        end else if (rel) begin
            rr_ptr_nx   = gid;
            beat_cnt_nx = '0;
            state_nx    = pick_any ? GRANT : IDLE;
            gid_nx      = pick_any ? pick_idx : gid;
        end else if (xfer) begin
            beat_cnt_nx = beat_cnt + 1'b1;
        end
    end
    always_comb begin
        bus.req_ready      = '0;
        bus.req_ready[gid] = granted & ~bus.fifo_w_stall;
        bus.fifo_w_req     = xfer;
        bus.fifo_w_data    = xfer ? bus.req_data[gid*COL_BIT_WIDTH +: COL_BIT_WIDTH] : '0;
        bus.fifo_w_id      = granted ? gid : '0;
        bus.grant_active   = granted;
        bus.grant_id       = granted ? gid : '0;
    end
endmodule
